hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 19 +
 rtl/hazard_sb_entry.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the register hazard scoreboard.
// Optional feature macro: HAZARD_FORWARDING_EN (see hazard_scoreboard.sv).
package hazard_scoreboard_pkg;

  localparam int DEF_NUM_REGS     = 32;
  localparam int DEF_ALU_LATENCY  = 3;
  localparam int DEF_LOAD_LATENCY = 4;

  typedef enum logic {
    HAZ_ALU  = 1'b0,
    HAZ_LOAD = 1'b1
  } haz_kind_e;

  // Counter width able to hold values 0..max_lat.
  function automatic int cnt_width(input int max_lat);
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: countdown to writeback-visible plus a load flag.
// A new producer write (set_i) wins over the per-cycle decrement.
module hazard_sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int ALU_LATENCY  = DEF_ALU_LATENCY,
  parameter int LOAD_LATENCY = DEF_LOAD_LATENCY,
  parameter int CNT_W        = cnt_width(LOAD_LATENCY)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  haz_kind_e        kind_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ld_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_q, ld_d;

  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    if (set_i) begin
      cnt_d = (kind_i == HAZ_LOAD) ? CNT_W'(LOAD_LATENCY) : CNT_W'(ALU_LATENCY);
      ld_d  = (kind_i == HAZ_LOAD);
    end else if (!freeze_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ld_o  = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue hazard scoreboard: stalls decode on RAW hazards and mem_stall.
// Define HAZARD_FORWARDING_EN to allow bypass-ready sources and add fwd_rs1/fwd_rs2.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS       = DEF_NUM_REGS,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_LATENCY    = DEF_ALU_LATENCY,
  parameter int LOAD_LATENCY   = DEF_LOAD_LATENCY
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  input  logic                      issue_rs1_used,
  input  logic                      issue_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      issue_rd_we,
  input  logic                      issue_is_load,
  input  logic                      mem_stall,
  output logic                      stall,
`ifdef HAZARD_FORWARDING_EN
  output logic                      fwd_rs1,
  output logic                      fwd_rs2,
`endif
  output logic [31:0]               stall_cycles
);

  localparam int CNT_W = cnt_width(LOAD_LATENCY);

  // Handshake: issue_valid is the producer's valid, !stall is ready; the issue
  // is accepted (and updates the scoreboard) only in a cycle where both hold.
  logic [CNT_W-1:0] cnt_w [NUM_REGS];
  logic             ld_w  [NUM_REGS];
  logic             rs1_haz, rs2_haz, accept;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  assign cnt_w[0] = '0;
  assign ld_w[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(
      .ALU_LATENCY (ALU_LATENCY),
      .LOAD_LATENCY(LOAD_LATENCY),
      .CNT_W       (CNT_W)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .set_i   (accept && issue_rd_we && (issue_rd == REG_ADDR_WIDTH'(r))),
      .kind_i  (issue_is_load ? HAZ_LOAD : HAZ_ALU),
      .freeze_i(mem_stall),
      .cnt_o   (cnt_w[r]),
      .ld_o    (ld_w[r])
    );
  end

`ifdef HAZARD_FORWARDING_EN
  // Bypass network covers the last stages, so a producer is usable early.
  function automatic logic src_ready(input logic [CNT_W-1:0] c, input logic l);
    return int'(c) <= (l ? (LOAD_LATENCY - 2) : (ALU_LATENCY - 1));
  endfunction
`else
  function automatic logic src_ready(input logic [CNT_W-1:0] c, input logic l);
    return (c == '0) || (l && 1'b0);
  endfunction
`endif

  always_comb begin
    rs1_haz = issue_rs1_used && (issue_rs1 != '0) &&
              !src_ready(cnt_w[issue_rs1], ld_w[issue_rs1]);
    rs2_haz = issue_rs2_used && (issue_rs2 != '0) &&
              !src_ready(cnt_w[issue_rs2], ld_w[issue_rs2]);
    stall   = issue_valid && (rs1_haz || rs2_haz || mem_stall);
    accept  = issue_valid && !stall;
  end

`ifdef HAZARD_FORWARDING_EN
  always_comb begin
    fwd_rs1 = accept && issue_rs1_used && (issue_rs1 != '0) && (cnt_w[issue_rs1] != '0);
    fwd_rs2 = accept && issue_rs2_used && (issue_rs2 != '0) && (cnt_w[issue_rs2] != '0);
  end
`endif

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: timestamp-based reference model,
// directed scenarios plus randomized issue traffic.
module tb_hazard_scoreboard;

  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int ALU_LAT  = 3;
  localparam int LOAD_LAT = 4;
  localparam int W        = 35;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic          we;
    logic          ld;
  } ins_t;

  logic          clk;
  logic          reset;
  logic          issue_valid;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          issue_rs1_used, issue_rs2_used, issue_rd_we, issue_is_load;
  logic          mem_stall;
  logic          stall;
  logic [31:0]   stall_cycles;
  logic          fwd1_s, fwd2_s;
`ifdef HAZARD_FORWARDING_EN
  logic          fwd_rs1, fwd_rs2;
  assign fwd1_s = fwd_rs1;
  assign fwd2_s = fwd_rs2;
`else
  assign fwd1_s = 1'b0;
  assign fwd2_s = 1'b0;
`endif

  hazard_scoreboard #(
    .NUM_REGS      (NREG),
    .REG_ADDR_WIDTH(AW),
    .ALU_LATENCY   (ALU_LAT),
    .LOAD_LATENCY  (LOAD_LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rs1_used(issue_rs1_used),
    .issue_rs2_used(issue_rs2_used),
    .issue_rd      (issue_rd),
    .issue_rd_we   (issue_rd_we),
    .issue_is_load (issue_is_load),
    .mem_stall     (mem_stall),
    .stall         (stall),
`ifdef HAZARD_FORWARDING_EN
    .fwd_rs1       (fwd_rs1),
    .fwd_rs2       (fwd_rs2),
`endif
    .stall_cycles  (stall_cycles)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp, mon_act;
  logic [1:0]   last_fwd;

  task automatic check_eq(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {stall, fwd1_s, fwd2_s, stall_cycles};
      tests++;
      if (mon_act !== mon_exp) begin
        fails++;
        $display("FAIL cycle_check t=%0t: actual stall=%b fwd=%b%b cycles=%0d required stall=%b fwd=%b%b cycles=%0d",
                 $time, mon_act[34], mon_act[33], mon_act[32], mon_act[31:0],
                 mon_exp[34], mon_exp[33], mon_exp[32], mon_exp[31:0]);
      end
    end
  end

  // ---------------- reference model ----------------
  // Each register records the "active time" (count of non-frozen cycles) at
  // which its producer becomes writeback-visible.
  int unsigned busy_until [NREG];
  logic        ld_m       [NREG];
  int unsigned act_t;
  longint      sc_m;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      busy_until[i] = 0;
      ld_m[i]       = 1'b0;
    end
    act_t = 0;
    sc_m  = 0;
  endtask

  function automatic int unsigned rem(input int r);
    return (busy_until[r] > act_t) ? (busy_until[r] - act_t) : 0;
  endfunction

  function automatic logic ready_m(input int r);
`ifdef HAZARD_FORWARDING_EN
    return int'(rem(r)) <= (ld_m[r] ? (LOAD_LAT - 2) : (ALU_LAT - 1));
`else
    return rem(r) == 0;
`endif
  endfunction

  function automatic ins_t mk(input logic v, input int rd, input int rs1, input int rs2,
                              input logic u1, input logic u2, input logic we, input logic ld);
    ins_t t;
    t.valid = v; t.rd = AW'(rd); t.rs1 = AW'(rs1); t.rs2 = AW'(rs2);
    t.u1 = u1; t.u2 = u2; t.we = we; t.ld = ld;
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input ins_t ins, input logic ms, input logic rst, output logic dut_acc);
    logic h1, h2, es, acc_m, ef1, ef2;
    logic [31:0] esc;
    issue_valid    = ins.valid;
    issue_rd       = ins.rd;
    issue_rs1      = ins.rs1;
    issue_rs2      = ins.rs2;
    issue_rs1_used = ins.u1;
    issue_rs2_used = ins.u2;
    issue_rd_we    = ins.we;
    issue_is_load  = ins.ld;
    mem_stall      = ms;
    reset          = rst;
    h1    = ins.u1 && (ins.rs1 != 0) && !ready_m(int'(ins.rs1));
    h2    = ins.u2 && (ins.rs2 != 0) && !ready_m(int'(ins.rs2));
    es    = ins.valid && (h1 || h2 || ms);
    acc_m = ins.valid && !es;
`ifdef HAZARD_FORWARDING_EN
    ef1 = acc_m && ins.u1 && (ins.rs1 != 0) && (rem(int'(ins.rs1)) != 0);
    ef2 = acc_m && ins.u2 && (ins.rs2 != 0) && (rem(int'(ins.rs2)) != 0);
`else
    ef1 = 1'b0;
    ef2 = 1'b0;
`endif
    esc = (sc_m >= 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sc_m[31:0];
    exp_q.push_back({es, ef1, ef2, esc});
    #2;
    dut_acc  = issue_valid && !stall;
    last_fwd = {fwd1_s, fwd2_s};
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (es) sc_m++;
      if (!ms) act_t++;
      if (acc_m && ins.we && (ins.rd != 0)) begin
        busy_until[ins.rd] = act_t + (ins.ld ? LOAD_LAT : ALU_LAT);
        ld_m[ins.rd]       = ins.ld;
      end
    end
    #1;
  endtask

  // Present an instruction until the DUT accepts it; mem_stall asserted on
  // attempts [ms_start, ms_start+ms_len).
  task automatic issue_until_accept(input ins_t ins, input int ms_start, input int ms_len,
                                    output int stalls);
    logic acc;
    logic done;
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      drive_cycle(ins, (i >= ms_start) && (i < ms_start + ms_len), 1'b0, acc);
      if (acc) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: actual=not accepted after %0d cycles required=accepted", stalls);
    end
  endtask

  task automatic do_reset();
    logic acc;
    drive_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, acc);
  endtask

  // ---------------- stimulus ----------------
  ins_t nop, idle, cur;
  int   s, tot;
  logic acc;

  initial begin
    nop  = mk(1, 0, 0, 0, 1, 1, 1, 0);
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_rs1_used = 0; issue_rs2_used = 0; issue_rd_we = 0; issue_is_load = 0;
    mem_stall = 0; reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset state
    do_reset();
    check_eq("reset_stall_cycles", stall_cycles, 0);
    check_eq("reset_stall_idle", stall, 0);

    // nop chain
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      issue_until_accept(nop, 99, 0, s);
      tot += s;
    end
    check_eq("nop_chain_stalls", tot, 0);
    check_eq("nop_chain_stall_cycles", stall_cycles, 0);

    // ALU RAW
    do_reset();
    issue_until_accept(mk(1, 2, 1, 1, 1, 1, 1, 0), 99, 0, s);
    check_eq("alu_raw_producer_stalls", s, 0);
    issue_until_accept(mk(1, 3, 2, 2, 1, 1, 1, 0), 99, 0, s);
`ifdef HAZARD_FORWARDING_EN
    check_eq("alu_raw_stalls", s, 1);
    check_eq("alu_raw_stall_cycles", stall_cycles, 1);
`else
    check_eq("alu_raw_stalls", s, 3);
    check_eq("alu_raw_stall_cycles", stall_cycles, 3);
`endif

    // load-use
    do_reset();
    issue_until_accept(mk(1, 4, 1, 0, 1, 0, 1, 1), 99, 0, s);
    issue_until_accept(mk(1, 5, 4, 4, 1, 1, 1, 0), 99, 0, s);
`ifdef HAZARD_FORWARDING_EN
    check_eq("load_use_stalls", s, 2);
    check_eq("load_use_fwd", last_fwd, 3);
`else
    check_eq("load_use_stalls", s, 4);
    check_eq("load_use_fwd", last_fwd, 0);
`endif

    // mem_stall freeze mid-countdown
    do_reset();
    issue_until_accept(mk(1, 2, 1, 1, 1, 1, 1, 0), 99, 0, s);
    issue_until_accept(mk(1, 3, 2, 2, 1, 1, 1, 0), 1, 2, s);
`ifdef HAZARD_FORWARDING_EN
    check_eq("freeze_stalls", s, 3);
    check_eq("freeze_stall_cycles", stall_cycles, 3);
`else
    check_eq("freeze_stalls", s, 5);
    check_eq("freeze_stall_cycles", stall_cycles, 5);
`endif

    // reset mid-countdown
    do_reset();
    issue_until_accept(mk(1, 2, 1, 1, 1, 1, 1, 0), 99, 0, s);
    do_reset();
    check_eq("reset_mid_idle_stall", stall, 0);
    issue_until_accept(mk(1, 3, 2, 2, 1, 1, 1, 0), 99, 0, s);
    check_eq("reset_mid_stalls", s, 0);
    check_eq("reset_mid_stall_cycles", stall_cycles, 0);

    // rewrite priority: second write to r2 lands while cnt[r2]=1
    do_reset();
    issue_until_accept(mk(1, 2, 0, 0, 1, 1, 1, 0), 99, 0, s);
    issue_until_accept(nop, 99, 0, s);
    issue_until_accept(nop, 99, 0, s);
    issue_until_accept(mk(1, 2, 0, 0, 1, 1, 1, 0), 99, 0, s);
    issue_until_accept(mk(1, 3, 2, 2, 1, 1, 1, 0), 99, 0, s);
`ifdef HAZARD_FORWARDING_EN
    check_eq("rewrite_priority_stalls", s, 1);
`else
    check_eq("rewrite_priority_stalls", s, 3);
`endif

    // randomized traffic; an instruction is held until accepted
    do_reset();
    cur = idle;
    for (int n = 0; n < 500; n++) begin
      if (!cur.valid || acc) begin
        cur = mk($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      drive_cycle(cur, $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0, acc);
    end

    drive_cycle(idle, 1'b0, 1'b0, acc);
    @(negedge clk);
    #1;
    check_eq("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
